// File: rtl/nand4_stim_checker.sv
// nand4_stim_checker: sweeps a..d through 0..15 and counts dut_out mismatches against EXPECT.
// Optional NAND4_STIM_FIRSTFAIL_EN adds fail_vec (vector of the first mismatch in a sweep).
`default_nettype none

module nand4_stim_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECT        = 16'h7FFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef NAND4_STIM_FIRSTFAIL_EN
  output logic [3:0] fail_vec,
`endif
  output logic [4:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  // With no settle time each vector goes straight to its sampling cycle.
  localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       w_accept;
  logic       w_mismatch;

  assign w_accept   = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign w_mismatch = (dut_out != EXPECT[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = 4'd0;
          err_d   = 5'd0;
          cnt_d   = SETTLE_INIT;
          state_d = FIRST_STATE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (w_mismatch && (err_q != 5'd16)) begin
          err_d = err_q + 5'd1;
        end
        if (vec_q == 4'd15) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = SETTLE_INIT;
          state_d = FIRST_STATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vec is 0 throughout IDLE and parks at 15 in DONE, so it drives a..d directly.
  assign a         = vec_q[0];
  assign b         = vec_q[1];
  assign c         = vec_q[2];
  assign d         = vec_q[3];
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 5'd0);
  assign err_count = err_q;

`ifdef NAND4_STIM_FIRSTFAIL_EN
  logic [3:0] fail_vec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_q <= 4'd0;
    end else if (w_accept) begin
      fail_vec_q <= 4'd0;
    end else if ((state_q == SAMPLE) && w_mismatch && (err_q == 5'd0)) begin
      fail_vec_q <= vec_q;
    end
  end

  assign fail_vec = fail_vec_q;
`endif

endmodule

`default_nettype wire
